// File: rtl/wptr_full_if.sv
// wptr_full_if: write-side FIFO bundle between the producer, the write RAM port and the pointer/flag logic.
interface wptr_full_if #(parameter int ADDRSIZE = 4);
  logic                winc;
  logic                wclr_ovf;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wfree;
  logic                woverflow;
  modport master(output winc, wclr_ovf, wq2_rptr,
                 input  wptr, waddr, wfull, walmost_full, wfree, woverflow);
  modport slave (input  winc, wclr_ovf, wq2_rptr,
                 output wptr, waddr, wfull, walmost_full, wfree, woverflow);
endinterface

// File: rtl/wptr_full.sv
// wptr_full: async-FIFO write pointer with registered full, almost-full, free count and sticky overflow.
module wptr_full #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = (1 << ADDRSIZE) - 2
) (
  input logic        wclk,
  input logic        wrst_n,
  wptr_full_if.slave bus
);
  localparam int W = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] DEPTH = W'(1 << ADDRSIZE);
  localparam logic [ADDRSIZE:0] AFULL = W'(AFULL_LEVEL);
  logic [ADDRSIZE:0] wbin, wbnext, wgnext, rbin_s, used_next;
  logic              wen;
  always_comb begin
    for (int i = 0; i <= ADDRSIZE; i++) rbin_s[i] = ^(bus.wq2_rptr >> i);
  end
  assign wen       = bus.winc & ~bus.wfull;
  assign wbnext    = wbin + W'(wen);
  assign wgnext    = (wbnext >> 1) ^ wbnext;
  assign used_next = wbnext - rbin_s;
  assign bus.waddr = wbin[ADDRSIZE-1:0];
  // Flags come from the next pointer so they stay consistent with wptr on the same edge.
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wbin             <= '0;
      bus.wptr         <= '0;
      bus.wfull        <= 1'b0;
      bus.walmost_full <= 1'b0;
      bus.wfree        <= DEPTH;
      bus.woverflow    <= 1'b0;
    end else begin
      wbin             <= wbnext;
      bus.wptr         <= wgnext;
      bus.wfull        <= wgnext == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
      bus.walmost_full <= used_next >= AFULL;
      bus.wfree        <= DEPTH - used_next;
      bus.woverflow    <= (bus.winc & bus.wfull) | (bus.woverflow & ~bus.wclr_ovf);
    end
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: directed test of wptr_full against a count-based FIFO occupancy model.
module tb_wptr_full;
  logic wclk = 1'b0;
  logic wrst_n = 1'b1;
  int   cmp = 0;
  int   errs = 0;
  bit   en = 1'b0;
  logic [4:0] prev = '0;
  int   m_wr, m_free;
  bit   m_full, m_af, m_ovf;
  wptr_full_if #(.ADDRSIZE(4)) bus();
  wptr_full #(.ADDRSIZE(4), .AFULL_LEVEL(14)) dut(.wclk(wclk), .wrst_n(wrst_n), .bus(bus));
  always #5 wclk = ~wclk;
  function automatic int gray(int b);
    return (b ^ (b >> 1)) & 31;
  endfunction
  function automatic int rd_count();
    for (int b = 0; b < 32; b++) if (gray(b) == int'(bus.wq2_rptr)) return b;
    return 0;
  endfunction
  function automatic int nw();
    return (m_wr + int'(bus.winc && !m_full)) % 32;
  endfunction
  function automatic int used();
    return (nw() - rd_count() + 32) % 32;
  endfunction
  // Model: FIFO occupancy = writes minus reads, modulo pointer range.
  always @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      m_wr <= 0; m_full <= 0; m_af <= 0; m_free <= 16; m_ovf <= 0;
    end else begin
      m_wr   <= nw();
      m_full <= used() == 16;
      m_af   <= used() >= 14;
      m_free <= 16 - used();
      m_ovf  <= (bus.winc && m_full) || (m_ovf && !bus.wclr_ovf);
    end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic compare();
    if (!en) return;
    chk("wptr", 32'(bus.wptr), 32'(gray(m_wr)));
    chk("waddr", 32'(bus.waddr), 32'(m_wr % 16));
    chk("wfull", 32'(bus.wfull), 32'(m_full));
    chk("walmost_full", 32'(bus.walmost_full), 32'(m_af));
    chk("wfree", 32'(bus.wfree), 32'(m_free));
    chk("woverflow", 32'(bus.woverflow), 32'(m_ovf));
    if (!wrst_n) prev = '0;
    else begin
      chk("wptr_step", 32'($countones(bus.wptr ^ prev) <= 1), 32'd1);
      prev = bus.wptr;
    end
  endtask
  task automatic cyc(bit w, bit c, logic [4:0] r);
    bus.winc = w; bus.wclr_ovf = c; bus.wq2_rptr = r;
    @(posedge wclk);
    @(negedge wclk);
  endtask
  task automatic reset_pulse();
    wrst_n = 1'b0;
    cyc(0, 0, 5'd0);
    wrst_n = 1'b1;
  endtask
  initial begin
    bus.winc = 0; bus.wclr_ovf = 0; bus.wq2_rptr = '0;
    fork
      forever begin @(negedge wclk); compare(); end
    join_none
    #2 wrst_n = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    en = 1'b1;
    cyc(0, 0, 5'd0);
    chk("rst_wptr", 32'(bus.wptr), 0);
    chk("rst_waddr", 32'(bus.waddr), 0);
    chk("rst_wfree", 32'(bus.wfree), 16);
    chk("rst_flags", {29'd0, bus.wfull, bus.walmost_full, bus.woverflow}, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 5'd0);
      if (i == 5) chk("waddr_after5", 32'(bus.waddr), 5);
      if (i == 13) chk("af_before14", 32'(bus.walmost_full), 0);
      if (i == 14) begin
        chk("af_at14", 32'(bus.walmost_full), 1);
        chk("free_at14", 32'(bus.wfree), 2);
      end
      if (i == 15) chk("full_at15", 32'(bus.wfull), 0);
    end
    chk("full_at16", 32'(bus.wfull), 1);
    chk("free_at16", 32'(bus.wfree), 0);
    chk("wptr_at16", 32'(bus.wptr), 32'b11000);
    cyc(1, 0, 5'd0);
    chk("ovf_wptr_hold", 32'(bus.wptr), 32'b11000);
    chk("ovf_set", 32'(bus.woverflow), 1);
    cyc(0, 1, 5'd0);
    chk("ovf_clear", 32'(bus.woverflow), 0);
    cyc(1, 0, 5'd0);
    cyc(1, 1, 5'd0);
    chk("ovf_set_and_clear", 32'(bus.woverflow), 1);
    cyc(0, 1, 5'd0);
    chk("ovf_clear2", 32'(bus.woverflow), 0);
    cyc(0, 0, 5'b00110);
    chk("release_full", 32'(bus.wfull), 0);
    chk("release_free", 32'(bus.wfree), 4);
    chk("release_af", 32'(bus.walmost_full), 0);
    reset_pulse();
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 5'(gray((i + 31) % 32)));
      if (bus.wfree < 14 || bus.wfree > 15) chk("lag_free_range", 32'(bus.wfree), 14);
      if (bus.wfull) chk("lag_never_full", 32'(bus.wfull), 0);
    end
    chk("lag_wrap_waddr", 32'(bus.waddr), 40 % 16);
    chk("lag_wrap_wptr", 32'(bus.wptr), 32'(gray(40 % 32)));
    reset_pulse();
    for (int i = 0; i < 7; i++) cyc(1, 0, 5'd0);
    chk("pre_rst_waddr", 32'(bus.waddr), 7);
    bus.winc = 0;
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    chk("async_wptr", 32'(bus.wptr), 0);
    chk("async_waddr", 32'(bus.waddr), 0);
    chk("async_wfree", 32'(bus.wfree), 16);
    chk("async_flags", {29'd0, bus.wfull, bus.walmost_full, bus.woverflow}, 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    bus.winc = 1;
    #1 chk("first_waddr", 32'(bus.waddr), 0);
    @(posedge wclk);
    @(negedge wclk);
    chk("after_first_waddr", 32'(bus.waddr), 1);
    chk("after_first_free", 32'(bus.wfree), 15);
    cyc(0, 0, 5'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 Parameter ADDRSIZE, default 4, SHALL set address width; FIFO depth DEPTH = 2^ADDRSIZE.
REQ-002 Parameter AFULL_LEVEL, default 2^ADDRSIZE-2, SHALL set the fill level at and above which walmost_full asserts; legal range 1..DEPTH.
REQ-003 wclk  input  1  write-domain clock; all state SHALL update on its rising edge.
REQ-004 wrst_n  input  1  reset; asynchronous, active-low.
REQ-005 winc  input  1  write request from the producer.
REQ-006 wq2_rptr  input  ADDRSIZE+1  Gray-coded read pointer, already two-flop synchronized into wclk.
REQ-007 wclr_ovf  input  1  clears the sticky overflow flag.
REQ-008 wptr  output  ADDRSIZE+1  registered Gray write pointer, for crossing to the read domain.
REQ-009 waddr  output  ADDRSIZE  binary write address to the RAM, equal to wbin[ADDRSIZE-1:0].
REQ-010 wfull  output  1  registered full flag.
REQ-011 walmost_full  output  1  registered almost-full flag.
REQ-012 wfree  output  ADDRSIZE+1  registered free-entry count, 0..DEPTH.
REQ-013 woverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 Block SHALL keep an internal binary pointer wbin, ADDRSIZE+1 bits, wrapping modulo 2^(ADDRSIZE+1).
REQ-015 Write accept: wen = winc & ~wfull; wbnext = wbin + wen; wgnext = (wbnext>>1) ^ wbnext.
REQ-016 Each cycle wbin <= wbnext and wptr <= wgnext; wptr SHALL change by at most one bit per cycle.
REQ-017 waddr SHALL reflect the current wbin, so RAM write uses waddr with enable wen in the same cycle.
REQ-018 Full detect: wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}); the write that fills the last entry SHALL raise wfull on the next edge.
REQ-019 Block SHALL convert wq2_rptr to binary rbin_s (XOR prefix from MSB) combinationally.
REQ-020 Fill: used_next = (wbnext - rbin_s) mod 2^(ADDRSIZE+1), range 0..DEPTH.
REQ-021 wfree <= DEPTH - used_next; walmost_full <= (used_next >= AFULL_LEVEL).
REQ-022 wfull, walmost_full and wfree SHALL be mutually consistent in the same cycle: wfull=1 implies wfree=0 and walmost_full=1.
REQ-023 winc while wfull=1 SHALL leave wbin, wptr and waddr unchanged and SHALL set woverflow on the next edge.
REQ-024 woverflow SHALL hold until a cycle with wclr_ovf=1 and no new overflow; simultaneous set and clear SHALL leave woverflow=1.
REQ-025 Pointer wrap (wbin from 2^(ADDRSIZE+1)-1 to 0) SHALL not disturb full, free or almost-full computation.
REQ-026 Stale wq2_rptr (read side advanced but not yet visible) SHALL only make flags pessimistic, never optimistic: wfull may deassert late, never early.
REQ-027 Full release: when synchronized read pointer advances, wfull SHALL deassert on the next edge with wfree updated the same edge.

Reset
REQ-028 wrst_n low SHALL immediately force wbin=0, wptr=0, wfull=0, walmost_full=0, wfree=DEPTH, woverflow=0, asynchronously to wclk.
REQ-029 Reset asserted mid-operation SHALL discard pending writes; the first write after release (wrst_n high at a wclk edge) SHALL use waddr=0.
REQ-030 Reset release SHALL be synchronous to wclk by the integrating design; the block SHALL not sample inputs while wrst_n is low.

Verification (ADDRSIZE=4, AFULL_LEVEL=14, wq2_rptr held 0 unless stated)
REQ-031 Reset then idle -> wptr=0, waddr=0, wfree=16, wfull=0, walmost_full=0, woverflow=0.
REQ-032 16 consecutive winc -> waddr 0..15; walmost_full=1 after 14th edge, wfree=2; wfull=1 and wfree=0 after 16th edge; wptr=5'b11000.
REQ-033 Full, one more winc -> wptr unchanged, woverflow=1 next edge; wclr_ovf pulse -> woverflow=0; wclr_ovf with concurrent overflow -> woverflow stays 1.
REQ-034 Full, then wq2_rptr set to Gray(4)=5'b00110 -> next edge wfull=0, wfree=4, walmost_full=0.
REQ-035 Run 40 writes with wq2_rptr tracking written pointer lagging by 2 -> wrap past 31 to 0, wfree constantly 14 or 15, wfull never asserted, wptr single-bit changes only.
REQ-036 Assert wrst_n low between edges after 7 writes -> outputs reach reset values without a wclk edge; next accepted write uses waddr=0.
